scan_chain_driver: RTL

- On-chip scan master that sits directly upstream of scan_full and drives its pad-side pins: scan_phi, scan_phi_bar, scan_data_in, scan_load_chip, scan_load_chain and scan_id.
- Accepts one parallel command (op, chain id, CHAIN_LEN-bit frame) through a valid/ready handshake and serialises it with non-overlapping two-phase scan clocks.
- Captures scan_data_out bit by bit and returns the shifted-out frame as a response.
- Replaces the bit-banged stimulus, so firmware and benches program the SRAM/ctr/lane_id/id_sel chain with single transactions.

---
 rtl/scan_drv_pkg.sv | 29 ++
 rtl/scan_chain_driver_phase.sv | 63 ++++++
 rtl/scan_chain_driver.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/scan_drv_pkg.sv
// Shared types for the scan chain driver: command opcodes, FSM states and
// the per-bit cycle count helper.
package scan_drv_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_READ  = 2'd1,
    OP_XCHG  = 2'd2,
    OP_ILL   = 2'd3
  } op_e;

  typedef enum logic [3:0] {
    IDLE,
    CAPT,
    SETUP,
    PHI,
    GAP1,
    PHIB,
    GAP2,
    UPD,
    RESP
  } state_e;

  // Clock cycles spent on one chain bit: setup, two phase pulses, two gaps.
  function automatic int bit_cycles(input int phi_cyc, input int gap_cyc);
    return 1 + 2 * phi_cyc + 2 * gap_cyc;
  endfunction

endpackage

// File: rtl/scan_chain_driver_phase.sv
// Two-phase non-overlapping clock generator for one scan bit: on start it
// runs PHI, GAP1, PHIB, GAP2 and flags the last GAP2 cycle with bit_done.
module scan_phase_gen
  import scan_drv_pkg::*;
#(
  parameter int PHI_CYC = 2,
  parameter int GAP_CYC = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic scan_phi,
  output logic scan_phi_bar,
  output logic bit_done
);

  localparam int MAX_CYC = (PHI_CYC > GAP_CYC) ? PHI_CYC : GAP_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);

  state_e        ps, ps_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          last;

  always_comb begin
    last = 1'b0;
    case (ps)
      PHI, PHIB:  last = (cnt == CW'(PHI_CYC - 1));
      GAP1, GAP2: last = (cnt == CW'(GAP_CYC - 1));
      default:    last = 1'b0;
    endcase
  end

  always_comb begin
    ps_d = ps;
    case (ps)
      IDLE:    if (start) ps_d = PHI;
      PHI:     if (last)  ps_d = GAP1;
      GAP1:    if (last)  ps_d = PHIB;
      PHIB:    if (last)  ps_d = GAP2;
      GAP2:    if (last)  ps_d = IDLE;
      default: ps_d = IDLE;
    endcase
  end

  assign cnt_d    = (ps_d != ps || ps == IDLE) ? '0 : cnt + 1'b1;
  assign bit_done = (ps == GAP2) && last;

  // Phase pins are decoded from the next state so they leave a flop directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      ps           <= IDLE;
      cnt          <= '0;
      scan_phi     <= 1'b0;
      scan_phi_bar <= 1'b0;
    end else begin
      ps           <= ps_d;
      cnt          <= cnt_d;
      scan_phi     <= (ps_d == PHI);
      scan_phi_bar <= (ps_d == PHIB);
    end
  end

endmodule

// File: rtl/scan_chain_driver.sv
// Scan master: takes one parallel command, captures/shifts/updates the scan
// chain with two-phase clocks and returns the shifted-out frame.
module scan_chain_driver
  import scan_drv_pkg::*;
#(
  parameter int CHAIN_LEN = 64,
  parameter int PHI_CYC   = 2,
  parameter int GAP_CYC   = 1,
  parameter int LOAD_CYC  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic                 cmd_id,
  input  logic [CHAIN_LEN-1:0] cmd_data,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [CHAIN_LEN-1:0] rsp_data,
  output logic                 rsp_err,
  output logic                 scan_id,
  output logic                 scan_phi,
  output logic                 scan_phi_bar,
  output logic                 scan_data_in,
  input  logic                 scan_data_out,
  output logic                 scan_load_chip,
  output logic                 scan_load_chain
);

  if (CHAIN_LEN < 2 || PHI_CYC < 1 || GAP_CYC < 1 || LOAD_CYC < 1) begin : g_param_check
    $error("scan_chain_driver: illegal parameter set");
  end

  localparam int BW = $clog2(CHAIN_LEN);
  localparam int LW = $clog2(LOAD_CYC + 1);

  state_e                 state, state_d;
  op_e                    op_q;
  logic [BW-1:0]          bcnt;
  logic [LW-1:0]          lcnt;
  logic [CHAIN_LEN-1:0]   data_sr, rsp_sr;
  logic                   accept, load_done, bit_start, bit_done, rsp_hs;
  logic                   load_chain_d, load_chip_d, rsp_valid_d, rsp_err_d;

  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign load_done = (lcnt == LW'(LOAD_CYC - 1));
  assign bit_start = (state == SETUP);
  assign rsp_hs    = rsp_valid && rsp_ready;
  assign rsp_data  = rsp_valid ? rsp_sr : '0;

  scan_phase_gen #(
    .PHI_CYC (PHI_CYC),
    .GAP_CYC (GAP_CYC)
  ) u_phase (
    .clk          (clk),
    .rst          (rst),
    .start        (bit_start),
    .scan_phi     (scan_phi),
    .scan_phi_bar (scan_phi_bar),
    .bit_done     (bit_done)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // PHI stands for the whole phase sequence run by the phase generator.
  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (accept) begin
          case (op_e'(cmd_op))
            OP_WRITE:         state_d = SETUP;
            OP_READ, OP_XCHG: state_d = CAPT;
            default:          state_d = RESP;
          endcase
        end
      end
      CAPT:  if (load_done) state_d = SETUP;
      SETUP: state_d = PHI;
      PHI: begin
        if (bit_done) begin
          if (bcnt != '0)             state_d = SETUP;
          else if (op_q == OP_READ)   state_d = RESP;
          else                        state_d = UPD;
        end
      end
      UPD:     if (load_done) state_d = RESP;
      RESP:    if (rsp_hs)    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load_chain_d = (state_d == CAPT);
    load_chip_d  = (state_d == UPD);
    rsp_valid_d  = (state == RESP) && !rsp_hs;
    rsp_err_d    = (state == RESP) && !rsp_hs && (op_q == OP_ILL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_load_chain <= 1'b0;
      scan_load_chip  <= 1'b0;
      rsp_valid       <= 1'b0;
      rsp_err         <= 1'b0;
    end else begin
      scan_load_chain <= load_chain_d;
      scan_load_chip  <= load_chip_d;
      rsp_valid       <= rsp_valid_d;
      rsp_err         <= rsp_err_d;
    end
  end

  // Sequencing counters and the registered serial pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt         <= '0;
      lcnt         <= '0;
      scan_id      <= 1'b0;
      scan_data_in <= 1'b0;
    end else begin
      if (accept) begin
        scan_id <= cmd_id;
        bcnt    <= BW'(CHAIN_LEN - 1);
      end else if (state == PHI && bit_done && bcnt != '0) begin
        bcnt <= bcnt - 1'b1;
      end
      if ((state == CAPT || state == UPD) && !load_done) lcnt <= lcnt + 1'b1;
      else                                               lcnt <= '0;
      if (bit_start)
        scan_data_in <= (op_q == OP_READ) ? scan_data_out : data_sr[CHAIN_LEN-1];
    end
  end

  // Frame registers: the chain output is sampled as the next bit is driven.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q    <= op_e'(cmd_op);
      data_sr <= cmd_data;
      rsp_sr  <= '0;
    end else if (bit_start) begin
      data_sr <= {data_sr[CHAIN_LEN-2:0], 1'b0};
      rsp_sr  <= {rsp_sr[CHAIN_LEN-2:0], scan_data_out};
    end
  end

endmodule
